// File: rtl/ultrasonic_pkg.sv
// Shared constants, FSM encoding and the result record for the ultrasonic ranging path.
// The zone helper is also used wherever a distance must be quantised for the motor block.
package ultrasonic_pkg;

    localparam int DIST_W = 9;
    localparam int ZONE_W = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_COOLDOWN  = 3'd4;

    localparam logic [ZONE_W-1:0] ZONE_MAX = '1;

    typedef struct packed {
        logic [DIST_W-1:0] dist_cm;
        logic [ZONE_W-1:0] zone;
        logic              timeout;
    } range_result_t;

    // Coarse distance bucket; anything past the top bucket reads as the farthest zone.
    function automatic logic [ZONE_W-1:0] zone_of(input logic [DIST_W-1:0] cm,
                                                   input int unsigned      shift);
        logic [DIST_W-1:0] q;
        q = cm >> shift;
        if (q > {{(DIST_W-ZONE_W){1'b0}}, ZONE_MAX}) begin
            return ZONE_MAX;
        end
        return q[ZONE_W-1:0];
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Prescaler producing a single-cycle tick every DIV clocks.
// While hold is high the count parks at zero, so the first tick lands DIV clocks after release.
module us_tick_gen #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !hold && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ultrasonic_ranging_ctrl.sv
// Periodic HC-SR04 style ranging sequencer: fires the trigger, times the echo in 1 us ticks,
// converts to centimetres and publishes distance, zone and timeout with a one-cycle strobe.
module ultrasonic_ranging_ctrl
    import ultrasonic_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int PERIOD_US  = 60000,
    parameter int CM_US      = 58,
    parameter int MAX_CM     = 400,
    parameter int ZONE_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              timeout,
    output logic [ZONE_W-1:0] zone,
    output logic              busy
);

    localparam int US_DIV = CLK_HZ / 1_000_000;
    localparam int CNT_W  = $clog2(PERIOD_US + 1);
    localparam int SUB_W  = (CM_US > 1) ? $clog2(CM_US) : 1;

    localparam logic [CNT_W-1:0]  TRIG_LAST    = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0]  PERIOD_LAST  = CNT_W'(PERIOD_US - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST     = SUB_W'(CM_US - 1);
    localparam logic [DIST_W-1:0] CM_SAT       = DIST_W'(MAX_CM);

    logic [2:0]        state_q, state_d;
    logic              trig_q, trig_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    range_result_t     result_q, result_d;
    logic [CNT_W-1:0]  us_cnt_q, us_cnt_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic              echo_s1_q, echo_s1_d;
    logic              echo_s2_q, echo_s2_d;
    logic              echo_dly_q, echo_dly_d;

    logic              tick;
    logic              echo_rise;
    logic              echo_fall;
    logic              pub_normal;
    logic              pub_timeout;
    logic [DIST_W-1:0] cm_step;
    logic [SUB_W-1:0]  sub_step;

    us_tick_gen #(
        .DIV (US_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .hold (state_q == ST_IDLE),
        .tick (tick)
    );

    assign echo_rise = echo_s2_q && !echo_dly_q;
    assign echo_fall = !echo_s2_q && echo_dly_q;

    // Accumulator value after this cycle's tick, so a tick coinciding with the fall still counts.
    always_comb begin
        cm_step  = cm_q;
        sub_step = sub_q;
        if (tick) begin
            if (sub_q == SUB_LAST) begin
                sub_step = '0;
                if (cm_q < CM_SAT) begin
                    cm_step = cm_q + 1'b1;
                end
            end else begin
                sub_step = sub_q + 1'b1;
            end
        end
    end

    always_comb begin
        echo_s1_d    = echo;
        echo_s2_d    = echo_s1_q;
        echo_dly_d   = echo_s2_q;
        state_d      = state_q;
        us_cnt_d     = us_cnt_q;
        period_cnt_d = period_cnt_q;
        cm_d         = cm_q;
        sub_d        = sub_q;
        result_d     = result_q;
        valid_d      = 1'b0;
        pub_normal   = 1'b0;
        pub_timeout  = 1'b0;

        if (tick) begin
            period_cnt_d = period_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                us_cnt_d = '0;
                if (en) begin
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (tick) begin
                    if (us_cnt_q == TRIG_LAST) begin
                        state_d  = ST_WAIT_RISE;
                        us_cnt_d = '0;
                    end else begin
                        us_cnt_d = us_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d  = ST_MEASURE;
                    us_cnt_d = '0;
                    cm_d     = '0;
                    sub_d    = '0;
                end else if (tick) begin
                    if (us_cnt_q == TIMEOUT_LAST) begin
                        pub_timeout = 1'b1;
                        state_d     = ST_COOLDOWN;
                    end else begin
                        us_cnt_d = us_cnt_q + 1'b1;
                    end
                end
            end
            ST_MEASURE: begin
                cm_d  = cm_step;
                sub_d = sub_step;
                // A fall in the same cycle as the last timeout tick is still a valid echo.
                if (echo_fall) begin
                    pub_normal = 1'b1;
                    state_d    = ST_COOLDOWN;
                end else if (tick) begin
                    if (us_cnt_q == TIMEOUT_LAST) begin
                        pub_timeout = 1'b1;
                        state_d     = ST_COOLDOWN;
                    end else begin
                        us_cnt_d = us_cnt_q + 1'b1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick && (period_cnt_q == PERIOD_LAST)) begin
                    state_d = en ? ST_TRIG : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_TRIG) && (state_q != ST_TRIG)) begin
            period_cnt_d = '0;
            us_cnt_d     = '0;
        end

        if (pub_normal) begin
            result_d.dist_cm = cm_step;
            result_d.zone    = zone_of(cm_step, ZONE_SHIFT);
            result_d.timeout = 1'b0;
            valid_d          = 1'b1;
        end else if (pub_timeout) begin
            result_d.dist_cm = CM_SAT;
            result_d.zone    = ZONE_MAX;
            result_d.timeout = 1'b1;
            valid_d          = 1'b1;
        end

        trig_d = (state_d == ST_TRIG);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            result_q     <= '0;
            us_cnt_q     <= '0;
            period_cnt_q <= '0;
            cm_q         <= '0;
            sub_q        <= '0;
            echo_s1_q    <= 1'b0;
            echo_s2_q    <= 1'b0;
            echo_dly_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            result_q     <= result_d;
            us_cnt_q     <= us_cnt_d;
            period_cnt_q <= period_cnt_d;
            cm_q         <= cm_d;
            sub_q        <= sub_d;
            echo_s1_q    <= echo_s1_d;
            echo_s2_q    <= echo_s2_d;
            echo_dly_q   <= echo_dly_d;
        end
    end

    assign trig       = trig_q;
    assign busy       = busy_q;
    assign dist_valid = valid_q;
    assign dist_cm    = result_q.dist_cm;
    assign zone       = result_q.zone;
    assign timeout    = result_q.timeout;

endmodule
